// File: rtl/muldiv_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide sequencer: FSM states,
// operation codes and the default watchdog length.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEFAULT_TIMEOUT = 40;

endpackage

// File: rtl/muldiv_if.sv
// Handshake bundle between the sequencer (master) and the external
// multiplier/divider units (slave).
interface muldiv_if;

    logic        div_start;
    logic        div_end;
    logic        div_zero;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    logic        mult_start;
    logic        mult_end;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;

    modport master (
        output div_start, mult_start,
        input  div_end, div_zero, div_hi, div_lo,
        input  mult_end, mult_hi, mult_lo
    );

    modport slave (
        input  div_start, mult_start,
        output div_end, div_zero, div_hi, div_lo,
        output mult_end, mult_hi, mult_lo
    );

endinterface

// File: rtl/muldiv_watchdog.sv
// Down-counter that bounds how long the sequencer waits for a unit; only
// instantiated when MULDIV_TIMEOUT_EN is defined.
module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = W'(TIMEOUT);
        end else if (count_en && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the last waiting cycle, i.e. the one that would reach zero.
    assign expired = count_en && (count_q == W'(1));

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer for the architectural Hi/Lo registers: launches the external
// multiplier or divider and commits its result. MULDIV_TIMEOUT_EN adds a wait watchdog.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_req,
    input  logic        op_sel,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    muldiv_if.master    unit,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        timeout_exc
);

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [31:0] hold_hi_q, hold_hi_d;
    logic [31:0] hold_lo_q, hold_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div_start_q, div_start_d;
    logic        mult_start_q, mult_start_d;
    logic        div_zero_exc_q, div_zero_exc_d;
    logic        sel_end;

`ifdef MULDIV_TIMEOUT_EN
    logic timeout_hit;
    logic timeout_exc_q, timeout_exc_d;

    muldiv_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == START),
        .count_en (state_q == WAIT),
        .expired  (timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        hold_hi_d      = hold_hi_q;
        hold_lo_d      = hold_lo_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        div_start_d    = 1'b0;
        mult_start_d   = 1'b0;
        done_d         = 1'b0;
        div_zero_exc_d = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
        timeout_exc_d  = 1'b0;
`endif
        sel_end = (op_q == OP_DIV) ? unit.div_end : unit.mult_end;

        case (state_q)
            IDLE: begin
                // A request takes precedence over a coincident MTHI/MTLO write.
                if (op_req) begin
                    op_d         = op_sel;
                    state_d      = START;
                    div_start_d  = (op_sel == OP_DIV);
                    mult_start_d = (op_sel == OP_MULT);
                end else if (mt_we) begin
                    if (mt_sel) lo_d = mt_data;
                    else        hi_d = mt_data;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (op_q == OP_DIV && unit.div_zero) begin
                    div_zero_exc_d = 1'b1;
                    state_d        = IDLE;
                end else if (sel_end) begin
                    hold_hi_d = (op_q == OP_DIV) ? unit.div_hi : unit.mult_hi;
                    hold_lo_d = (op_q == OP_DIV) ? unit.div_lo : unit.mult_lo;
                    state_d   = WRITE;
                end
`ifdef MULDIV_TIMEOUT_EN
                else if (timeout_hit) begin
                    timeout_exc_d = 1'b1;
                    state_d       = IDLE;
                end
`endif
            end
            WRITE: begin
                hi_d    = hold_hi_q;
                lo_d    = hold_lo_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= OP_MULT;
            hold_hi_q      <= '0;
            hold_lo_q      <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            div_start_q    <= 1'b0;
            mult_start_q   <= 1'b0;
            div_zero_exc_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            hold_hi_q      <= hold_hi_d;
            hold_lo_q      <= hold_lo_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            div_start_q    <= div_start_d;
            mult_start_q   <= mult_start_d;
            div_zero_exc_q <= div_zero_exc_d;
        end
    end

`ifdef MULDIV_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) timeout_exc_q <= 1'b0;
        else       timeout_exc_q <= timeout_exc_d;
    end
    assign timeout_exc = timeout_exc_q;
`else
    assign timeout_exc = 1'b0;
`endif

    assign hi_out          = hi_q;
    assign lo_out          = lo_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign div_zero_exc    = div_zero_exc_q;
    assign unit.div_start  = div_start_q;
    assign unit.mult_start = mult_start_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised scoreboard bench for muldiv_seq with behavioural unit stubs;
// the watchdog scenario runs only when MULDIV_TIMEOUT_EN is defined.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int TB_TIMEOUT = 40;

    // Event kinds the scoreboard expects.
    localparam int EV_DONE = 0;
    localparam int EV_DZ   = 1;
    localparam int EV_TO   = 2;

    typedef struct {
        int          kind;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        op_req, op_sel, mt_we, mt_sel;
    logic [31:0] mt_data;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero_exc, timeout_exc;

    muldiv_if uif ();

    muldiv_seq #(
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op_req       (op_req),
        .op_sel       (op_sel),
        .mt_we        (mt_we),
        .mt_sel       (mt_sel),
        .mt_data      (mt_data),
        .unit         (uif),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .timeout_exc  (timeout_exc)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    int          stub_lat = 1;
    logic        stub_zero = 1'b0;
    logic [31:0] stub_hi = '0;
    logic [31:0] stub_lo = '0;
    bit          stub_abort = 1'b0;
    bit          stub_div;
    int          stub_n;

    int          div_pulses = 0;
    int          mult_pulses = 0;
    bit          prev_event = 1'b0;
    int          ev_count;
    int          ev_kind;
    exp_t        got;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (50000) @(posedge clk);
        $display("[TB] FAIL global_timeout: got %0d cycles, required completion earlier", cyc);
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Behavioural multiplier/divider: answers after stub_lat cycles while the unselected unit chatters.
    always begin
        @(negedge clk);
        if (uif.div_start || uif.mult_start) begin
            stub_div = uif.div_start;
            stub_n   = 0;
            forever begin
                @(posedge clk); #1;
                stub_n++;
                if (stub_div) begin
                    uif.mult_end = 1'($urandom_range(0, 1));
                    uif.mult_hi  = $urandom;
                    uif.mult_lo  = $urandom;
                    uif.div_end  = 1'b0;
                    uif.div_zero = 1'b0;
                end else begin
                    uif.div_end  = 1'($urandom_range(0, 1));
                    uif.div_zero = 1'($urandom_range(0, 1));
                    uif.div_hi   = $urandom;
                    uif.div_lo   = $urandom;
                    uif.mult_end = 1'b0;
                end
                if (stub_abort) break;
                if (stub_lat != 0 && stub_n == stub_lat) begin
                    if (stub_div && stub_zero) begin
                        uif.div_zero = 1'b1;
                        uif.div_end  = 1'($urandom_range(0, 1));
                        uif.div_hi   = $urandom;
                        uif.div_lo   = $urandom;
                    end else if (stub_div) begin
                        uif.div_end = 1'b1;
                        uif.div_hi  = stub_hi;
                        uif.div_lo  = stub_lo;
                    end else begin
                        uif.mult_end = 1'b1;
                        uif.mult_hi  = stub_hi;
                        uif.mult_lo  = stub_lo;
                    end
                    break;
                end
            end
            @(posedge clk); #1;
            uif.div_end  = 1'b0;
            uif.div_zero = 1'b0;
            uif.mult_end = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever a completion/exception pulse appears.
    always @(negedge clk) begin
        if (!reset) begin
            if (uif.div_start)  div_pulses++;
            if (uif.mult_start) mult_pulses++;
            ev_count = int'(done) + int'(div_zero_exc) + int'(timeout_exc);
            if (ev_count > 0) begin
                checkOutput("event_exclusive", ev_count, 1);
                checkOutput("event_back_to_back", 32'(prev_event), 0);
                ev_kind = done ? EV_DONE : (div_zero_exc ? EV_DZ : EV_TO);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_event", ev_kind, 32'hFFFF_FFFF);
                end else begin
                    got = sb.pop_front();
                    checkOutput("event_kind", ev_kind, got.kind);
                    checkOutput("event_cycle", cyc, got.cyc);
                    checkOutput("event_hi", hi_out, got.hi);
                    checkOutput("event_lo", lo_out, got.lo);
                    checkOutput("event_busy", 32'(busy), 0);
                end
            end
            prev_event = (ev_count > 0);
        end
    end

    task automatic mtWrite(input logic sel, input logic [31:0] data);
        @(posedge clk); #1;
        mt_we = 1'b1; mt_sel = sel; mt_data = data;
        @(posedge clk); #1;
        mt_we = 1'b0;
        if (sel) model_lo = data;
        else     model_hi = data;
    endtask

    // lat == 0 means the selected unit never answers (watchdog scenario).
    task automatic applyStimulus(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                 input int lat, input bit inject, input bit with_mt);
        exp_t   e;
        int     off;
        longint p;
        stub_zero = 1'b0;
        stub_hi   = $urandom;
        stub_lo   = $urandom;
        if (lat == 0) begin
            e.kind = EV_TO; e.hi = model_hi; e.lo = model_lo; off = TB_TIMEOUT + 2;
        end else if (is_div && b == 0) begin
            stub_zero = 1'b1;
            e.kind = EV_DZ; e.hi = model_hi; e.lo = model_lo; off = lat + 2;
        end else if (is_div) begin
            stub_lo = int'(a) / int'(b);
            stub_hi = int'(a) % int'(b);
            e.kind = EV_DONE; e.hi = stub_hi; e.lo = stub_lo; off = lat + 3;
        end else begin
            p = longint'(int'(a)) * longint'(int'(b));
            stub_hi = p[63:32];
            stub_lo = p[31:0];
            e.kind = EV_DONE; e.hi = stub_hi; e.lo = stub_lo; off = lat + 3;
        end
        if (e.kind == EV_DONE) begin
            model_hi = e.hi;
            model_lo = e.lo;
        end
        stub_lat    = lat;
        div_pulses  = 0;
        mult_pulses = 0;

        @(posedge clk); #1;
        op_req = 1'b1; op_sel = is_div;
        if (with_mt) begin
            mt_we = 1'b1; mt_sel = 1'($urandom_range(0, 1)); mt_data = $urandom;
        end
        e.cyc = cyc + off;
        sb.push_back(e);
        @(posedge clk); #1;
        op_req = 1'b0; mt_we = 1'b0;
        @(negedge clk);
        checkOutput("busy_during_op", 32'(busy), 1);
        if (inject) begin
            @(posedge clk); #1;
            op_req = 1'b1; op_sel = 1'($urandom_range(0, 1));
            mt_we = 1'b1; mt_sel = 1'($urandom_range(0, 1)); mt_data = $urandom;
            @(posedge clk); #1;
            op_req = 1'b0; mt_we = 1'b0;
        end

        for (int i = 0; i < off + 10 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("response_seen", 32'(sb.size()), 0);
        sb.delete();
        if (lat == 0) begin
            stub_abort = 1'b1;
            repeat (3) @(posedge clk);
            #1 stub_abort = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_hi", hi_out, model_hi);
        checkOutput("idle_lo", lo_out, model_lo);
        checkOutput("div_start_pulses", div_pulses, is_div ? 1 : 0);
        checkOutput("mult_start_pulses", mult_pulses, is_div ? 0 : 1);
    endtask

    initial begin
        logic        r_div;
        logic [31:0] r_a, r_b;
        reset = 1'b1;
        op_req = 1'b0; op_sel = 1'b0; mt_we = 1'b0; mt_sel = 1'b0; mt_data = '0;
        uif.div_end = 1'b0; uif.div_zero = 1'b0; uif.div_hi = '0; uif.div_lo = '0;
        uif.mult_end = 1'b0; uif.mult_hi = '0; uif.mult_lo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hi", hi_out, 0);
        checkOutput("reset_lo", lo_out, 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_div_start", 32'(uif.div_start), 0);
        checkOutput("reset_mult_start", 32'(uif.mult_start), 0);
        checkOutput("reset_dz_exc", 32'(div_zero_exc), 0);
        checkOutput("reset_to_exc", 32'(timeout_exc), 0);
        @(posedge clk); #1 reset = 1'b0;
        $display("[TB] reset released");

        applyStimulus(OP_DIV, 32'd100, 32'd7, 4, 1'b0, 1'b0);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 3, 1'b0, 1'b0);

        mtWrite(1'b0, 32'h11);
        mtWrite(1'b1, 32'h22);
        @(negedge clk);
        checkOutput("mthi", hi_out, 32'h11);
        checkOutput("mtlo", lo_out, 32'h22);
        applyStimulus(OP_DIV, 32'd5, 32'd0, 3, 1'b1, 1'b0);
        applyStimulus(OP_DIV, 32'd9, 32'd0, 1, 1'b0, 1'b1);

        applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 1'b0);

        for (int k = 0; k < 25; k++) begin
            r_div = 1'($urandom_range(0, 1));
            r_a   = $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1, 2:    r_b = 32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) r_b = 32'd1;
            if ($urandom_range(0, 2) == 0) mtWrite(1'($urandom_range(0, 1)), $urandom);
            applyStimulus(r_div, r_a, r_b, $urandom_range(1, 6),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        // Reset while waiting on the divider; its late answer must be dropped.
        stub_lat = 8; stub_zero = 1'b0; stub_hi = $urandom; stub_lo = $urandom;
        @(posedge clk); #1;
        op_req = 1'b1; op_sel = OP_DIV;
        @(posedge clk); #1;
        op_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        checkOutput("rst_wait_busy", 32'(busy), 0);
        checkOutput("rst_wait_hi", hi_out, 0);
        checkOutput("rst_wait_lo", lo_out, 0);
        repeat (12) @(negedge clk);
        checkOutput("late_end_hi", hi_out, 0);
        checkOutput("late_end_lo", lo_out, 0);
        checkOutput("late_end_busy", 32'(busy), 0);

        applyStimulus(OP_MULT, 32'd7, 32'd6, 2, 1'b0, 1'b0);

`ifdef MULDIV_TIMEOUT_EN
        applyStimulus(OP_DIV, 32'd50, 32'd3, 0, 1'b0, 1'b0);
        applyStimulus(OP_MULT, 32'd4, 32'd4, 0, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, the max WAIT cycles before abort (used only when MULDIV_TIMEOUT_EN is defined).
REQ-002 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port op_req  in  1  one-cycle request from the control unit to start an operation.
REQ-005 SHALL have port op_sel  in  1  operation select: 0 MULT, 1 DIV.
REQ-006 SHALL have ports mt_we  in  1, mt_sel  in  1 (0 Hi, 1 Lo) and mt_data  in  32, the MTHI/MTLO write.
REQ-007 SHALL have ports div_start  out  1, div_end  in  1, div_zero  in  1, div_hi  in  32, div_lo  in  32, the divider interface.
REQ-008 SHALL have ports mult_start  out  1, mult_end  in  1, mult_hi  in  32, mult_lo  in  32, the multiplier interface.
REQ-009 SHALL have ports hi_out  out  32 and lo_out  out  32, the architectural Hi/Lo registers.
REQ-010 SHALL have ports busy  out  1 (CPU stall), done  out  1 (completion pulse), div_zero_exc  out  1 and timeout_exc  out  1 (exception pulses).

Function
REQ-011 SHALL implement the states IDLE, START, WAIT and WRITE; busy SHALL be high in every state except IDLE.
REQ-012 IDLE: on op_req=1, SHALL latch op_sel and go to START next cycle; otherwise stay in IDLE.
REQ-013 START: SHALL drive exactly one start pulse (div_start if DIV, mult_start if MULT), the other held 0, then go to WAIT.
REQ-014 WAIT: SHALL sample only the selected unit's end/zero signals; signals from the other unit SHALL be ignored.
REQ-015 WAIT, DIV: div_zero=1 SHALL pulse div_zero_exc for one cycle, leave Hi/Lo unchanged and return to IDLE; div_zero SHALL take priority over div_end in the same cycle.
REQ-016 WAIT: selected end=1 SHALL capture the unit's hi/lo into holding registers and go to WRITE.
REQ-017 WRITE: SHALL update hi_out/lo_out, pulse done for one cycle and return to IDLE; latency from op_req to done SHALL be unit latency + 3 cycles.
REQ-018 op_req while busy SHALL be ignored (no queueing).
REQ-019 mt_we in IDLE SHALL write mt_data into the selected register on the next edge; mt_we while busy SHALL be ignored; if op_req and mt_we coincide in IDLE, op_req SHALL win and the write SHALL be dropped.
REQ-020 done, div_zero_exc and timeout_exc SHALL be mutually exclusive and never high for two consecutive cycles.

Reset
REQ-021 On reset SHALL enter IDLE with hi_out=lo_out=0, busy=done=div_start=mult_start=div_zero_exc=timeout_exc=0.
REQ-022 Reset mid-operation SHALL abandon the operation with no Hi/Lo update; the result of a later unit end SHALL be ignored.

Configuration
REQ-023 With MULDIV_TIMEOUT_EN defined: the counter SHALL load TIMEOUT in START and decrement in WAIT; reaching 0 without end/zero SHALL pulse timeout_exc, leave Hi/Lo unchanged and return to IDLE.
REQ-024 Without MULDIV_TIMEOUT_EN: no counter SHALL exist, timeout_exc SHALL be tied 0 and WAIT SHALL persist until end or zero.

Structure
REQ-025 Shared package muldiv_pkg SHALL hold the state encoding, OP_MULT=0, OP_DIV=1 and DEFAULT_TIMEOUT=40.
REQ-026 The timeout counter SHALL be the sub-module muldiv_watchdog, instantiated only under MULDIV_TIMEOUT_EN.

Verification
REQ-027 DIV a=100, b=7 -> one div_start pulse, done after divider end, hi_out=2, lo_out=14, busy low after done.
REQ-028 DIV a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
REQ-029 Preload Hi=0x11, Lo=0x22 via mt_we, then DIV b=0 -> div_zero_exc one cycle, no done, Hi/Lo stay 0x11/0x22.
REQ-030 MULT with a stub that asserts end 5 cycles after start with hi=0xA, lo=0xB -> hi_out=0xA, lo_out=0xB, done 8 cycles after op_req; an op_req and an mt_we issued during busy have no effect.
REQ-031 Reset asserted in WAIT -> IDLE next cycle, Hi/Lo=0, and a later div_end is ignored.
REQ-032 With MULDIV_TIMEOUT_EN and TIMEOUT=40, stub never ends -> timeout_exc after 40 WAIT cycles, then IDLE with Hi/Lo unchanged.
